counter_mode_d: RTL and testbench



---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_step_d.sv | 70 +++++++
 rtl/counter_mode_d.sv | 68 ++++++
 tb/tb_counter_mode_d.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the mode-selectable up/down counter family:
// end-of-range mode codes, FSM state encoding and a mode normalisation helper.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // The reserved code 2'b11 behaves exactly like wrap.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_WRAP : m;
    endfunction

endpackage

// File: rtl/counter_step_d.sv
// Combinational next-count generator: given the current count, terminal value,
// direction and mode, produces the stepped value plus wrap and one-shot events.
module counter_step_d
    import counter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] limit,
    input  logic         up,
    input  logic [1:0]   mode,
    output logic [W-1:0] q_next,
    output logic         wrap_evt,
    output logic         term_evt
);

    logic       at_top;
    logic       at_bot;
    logic [1:0] eff_mode;

    assign at_top   = (q >= limit);
    assign at_bot   = (q == '0);
    assign eff_mode = norm_mode(mode);

    always_comb begin
        q_next   = q;
        wrap_evt = 1'b0;
        term_evt = 1'b0;
        if (up) begin
            if (!at_top) begin
                q_next = q + 1'b1;
            end else begin
                // Saturate and one-shot both clamp, which also pulls q back
                // inside the range when limit was lowered below it.
                case (eff_mode)
                    MODE_SAT: begin
                        q_next = limit;
                    end
                    MODE_ONESHOT: begin
                        q_next   = limit;
                        term_evt = 1'b1;
                    end
                    default: begin
                        q_next   = '0;
                        wrap_evt = 1'b1;
                    end
                endcase
            end
        end else begin
            if (!at_bot) begin
                q_next = q - 1'b1;
            end else begin
                case (eff_mode)
                    MODE_SAT: begin
                        q_next = q;
                    end
                    MODE_ONESHOT: begin
                        q_next   = q;
                        term_evt = 1'b1;
                    end
                    default: begin
                        q_next   = limit;
                        wrap_evt = 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/counter_mode_d.sv
// Loadable up/down counter with programmable limit and wrap/saturate/one-shot
// end-of-range behaviour; holds the count, status registers and run/halt FSM.
module counter_mode_d
    import counter_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         up,
    input  logic [1:0]   mode,
    input  logic [W-1:0] limit,
    output logic [W-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap_pulse,
    output logic         done
);

    state_t       state;
    logic [W-1:0] q_next;
    logic         wrap_evt;
    logic         term_evt;
    logic [W-1:0] load_val;

    counter_step_d #(.W(W)) u_step (
        .q        (q),
        .limit    (limit),
        .up       (up),
        .mode     (mode),
        .q_next   (q_next),
        .wrap_evt (wrap_evt),
        .term_evt (term_evt)
    );

    assign load_val = (d > limit) ? limit : d;
    assign max_tick = (q == limit);
    assign min_tick = (q == '0);

    // Priority: reset, then load, then an enabled step while running, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= RST_VAL;
            wrap_pulse <= 1'b0;
            done       <= 1'b0;
            state      <= ST_RUN;
        end else if (load) begin
            q          <= load_val;
            wrap_pulse <= 1'b0;
            done       <= 1'b0;
            state      <= ST_RUN;
        end else if (enable && (state == ST_RUN)) begin
            q          <= q_next;
            wrap_pulse <= wrap_evt;
            if (term_evt) begin
                done  <= 1'b1;
                state <= ST_HALT;
            end
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_mode_d.sv
// Directed scoreboard bench for counter_mode_d (W=4): each step pushes the
// expected post-edge state, which is popped and checked after the edge.
module tb_counter_mode_d;

    localparam int W = 4;
    localparam logic [1:0] M_WRAP = 2'b00;
    localparam logic [1:0] M_SAT  = 2'b01;
    localparam logic [1:0] M_ONE  = 2'b10;
    localparam logic [1:0] M_RSV  = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         load;
    logic [W-1:0] d;
    logic         up;
    logic [1:0]   mode;
    logic [W-1:0] limit;
    logic [W-1:0] q;
    logic         max_tick;
    logic         min_tick;
    logic         wrap_pulse;
    logic         done;

    typedef struct {
        string        tag;
        logic [W-1:0] q;
        logic         wrap;
        logic         done;
        logic         max;
        logic         min;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    counter_mode_d #(.W(W), .RST_VAL(4'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .d          (d),
        .up         (up),
        .mode       (mode),
        .limit      (limit),
        .q          (q),
        .max_tick   (max_tick),
        .min_tick   (min_tick),
        .wrap_pulse (wrap_pulse),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput();
        exp_t e;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_empty: got size 0 want >0");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            assert (q === e.q) else begin
                bad++;
                $error("[TB] FAIL %s q: got %0d want %0d", e.tag, q, e.q);
            end
            total++;
            assert (wrap_pulse === e.wrap) else begin
                bad++;
                $error("[TB] FAIL %s wrap_pulse: got %b want %b", e.tag, wrap_pulse, e.wrap);
            end
            total++;
            assert (done === e.done) else begin
                bad++;
                $error("[TB] FAIL %s done: got %b want %b", e.tag, done, e.done);
            end
            total++;
            assert (max_tick === e.max) else begin
                bad++;
                $error("[TB] FAIL %s max_tick: got %b want %b", e.tag, max_tick, e.max);
            end
            total++;
            assert (min_tick === e.min) else begin
                bad++;
                $error("[TB] FAIL %s min_tick: got %b want %b", e.tag, min_tick, e.min);
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic ld,
                                 input logic [W-1:0] dv, input logic en, input logic u,
                                 input logic [1:0] m, input logic [W-1:0] lim,
                                 input logic [W-1:0] eq, input logic ew, input logic ed);
        exp_t e;
        @(negedge clk);
        rst    = r;
        load   = ld;
        d      = dv;
        enable = en;
        up     = u;
        mode   = m;
        limit  = lim;
        e.tag  = tag;
        e.q    = eq;
        e.wrap = ew;
        e.done = ed;
        e.max  = (eq == lim);
        e.min  = (eq == 4'd0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; d = '0; enable = 1'b0; up = 1'b1; mode = M_WRAP; limit = 4'd9;

        // tag, rst, load, d, en, up, mode, limit, exp q, exp wrap, exp done
        applyStimulus("reset", 1, 0, 0, 0, 1, M_WRAP, 9, 0, 0, 0);
        applyStimulus("hold_idle", 0, 0, 0, 0, 1, M_WRAP, 9, 0, 0, 0);

        // wrap 0..9 then back to 0 with a pulse, then onward to 1
        for (int i = 1; i <= 11; i++) begin
            applyStimulus("wrap_up", 0, 0, 0, 1, 1, M_WRAP, 9, 4'(i % 10), (i == 10), 0);
        end

        // saturate down from a load of 2
        applyStimulus("sat_load", 0, 1, 2, 0, 0, M_SAT, 5, 2, 0, 0);
        applyStimulus("sat_dn1", 0, 0, 0, 1, 0, M_SAT, 5, 1, 0, 0);
        applyStimulus("sat_dn0", 0, 0, 0, 1, 0, M_SAT, 5, 0, 0, 0);
        applyStimulus("sat_hold0a", 0, 0, 0, 1, 0, M_SAT, 5, 0, 0, 0);
        applyStimulus("sat_hold0b", 0, 0, 0, 1, 0, M_SAT, 5, 0, 0, 0);

        // one-shot up to 3: done on the enabled step taken at the top
        applyStimulus("os_load", 0, 1, 0, 0, 1, M_ONE, 3, 0, 0, 0);
        applyStimulus("os_1", 0, 0, 0, 1, 1, M_ONE, 3, 1, 0, 0);
        applyStimulus("os_2", 0, 0, 0, 1, 1, M_ONE, 3, 2, 0, 0);
        applyStimulus("os_3", 0, 0, 0, 1, 1, M_ONE, 3, 3, 0, 0);
        applyStimulus("os_term", 0, 0, 0, 1, 1, M_ONE, 3, 3, 0, 1);
        applyStimulus("os_halt_a", 0, 0, 0, 1, 0, M_ONE, 3, 3, 0, 1);
        applyStimulus("os_halt_b", 0, 0, 0, 1, 1, M_WRAP, 3, 3, 0, 1);
        applyStimulus("os_reload", 0, 1, 1, 1, 1, M_ONE, 3, 1, 0, 0);
        applyStimulus("os_rerun", 0, 0, 0, 1, 1, M_ONE, 3, 2, 0, 0);

        // load clamp, then reset beats a simultaneous load while halted
        applyStimulus("load_clamp", 0, 1, 12, 0, 1, M_ONE, 7, 7, 0, 0);
        applyStimulus("clamp_term", 0, 0, 0, 1, 1, M_ONE, 7, 7, 0, 1);
        applyStimulus("rst_over_load", 1, 1, 5, 1, 1, M_ONE, 7, 0, 0, 0);

        // limit lowered below the current count
        applyStimulus("rt_load8a", 0, 1, 8, 0, 1, M_WRAP, 15, 8, 0, 0);
        applyStimulus("rt_wrap", 0, 0, 0, 1, 1, M_WRAP, 4, 0, 1, 0);
        applyStimulus("rt_load8b", 0, 1, 8, 0, 1, M_SAT, 15, 8, 0, 0);
        applyStimulus("rt_sat", 0, 0, 0, 1, 1, M_SAT, 4, 4, 0, 0);
        applyStimulus("rt_load8c", 0, 1, 8, 0, 1, M_WRAP, 15, 8, 0, 0);
        applyStimulus("rt_down_noclamp", 0, 0, 0, 1, 0, M_WRAP, 4, 7, 0, 0);

        // limit of zero in each mode
        applyStimulus("z_load", 0, 1, 0, 0, 1, M_WRAP, 0, 0, 0, 0);
        applyStimulus("z_wrap_a", 0, 0, 0, 1, 1, M_WRAP, 0, 0, 1, 0);
        applyStimulus("z_wrap_b", 0, 0, 0, 1, 1, M_WRAP, 0, 0, 1, 0);
        applyStimulus("z_wrap_c", 0, 0, 0, 1, 1, M_WRAP, 0, 0, 1, 0);
        applyStimulus("z_en_off", 0, 0, 0, 0, 1, M_WRAP, 0, 0, 0, 0);
        applyStimulus("z_sat", 0, 0, 0, 1, 1, M_SAT, 0, 0, 0, 0);
        applyStimulus("z_oneshot", 0, 0, 0, 1, 1, M_ONE, 0, 0, 0, 1);

        // reserved mode wraps; down-wrap from zero reloads limit
        applyStimulus("rsv_load", 0, 1, 3, 0, 1, M_RSV, 3, 3, 0, 0);
        applyStimulus("rsv_wrap", 0, 0, 0, 1, 1, M_RSV, 3, 0, 1, 0);
        applyStimulus("dn_wrap", 0, 0, 0, 1, 0, M_WRAP, 3, 3, 1, 0);
        applyStimulus("dn_step", 0, 0, 0, 1, 0, M_WRAP, 3, 2, 0, 0);
        applyStimulus("os_dn_term", 0, 1, 0, 0, 0, M_ONE, 3, 0, 0, 0);
        applyStimulus("os_dn_halt", 0, 0, 0, 1, 0, M_ONE, 3, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
